// File: rtl/ysyx_22041412_div.sv
// ysyx_22041412_div -- iterative RV64M divide / remainder unit.
//
// Serves DIV/DIVU/REM/REMU and the W forms through the ALU's multi-cycle
// en/ready_o stall handshake. Signed operands are reduced to magnitudes,
// divided with a restoring shift/subtract loop, then sign-corrected.
// Divide-by-zero and signed overflow are resolved in a single cycle.
//
// Build option:
//   YSYX_22041412_DIV_RADIX4_EN  defined  : two quotient bits per cycle
//                                undefined: one quotient bit per cycle
//   Results are bit-identical; only the latency changes.
//
// Ports:
//   clk      in   clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   en       in   request, held by the ALU until ready_o
//   w_en     in   1 = 32-bit operation with sign-extended result
//   flush    in   abort any in-flight operation
//   rsA      in   dividend
//   rsB      in   divisor
//   func3    in   100 DIV, 101 DIVU, 110 REM, 111 REMU
//   ready_o  out  result valid this cycle (one-cycle pulse)
//   busy_o   out  iteration in progress
//   result   out  quotient or remainder, held until the next completion
module ysyx_22041412_div #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic            w_en,
  input  logic            flush,
  input  logic [XLEN-1:0] rsA,
  input  logic [XLEN-1:0] rsB,
  input  logic [2:0]      func3,
  output logic            ready_o,
  output logic            busy_o,
  output logic [XLEN-1:0] result
);

`ifdef YSYX_22041412_DIV_RADIX4_EN
  localparam logic [6:0] CNT_D = 7'd32;
  localparam logic [6:0] CNT_W = 7'd16;
`else
  localparam logic [6:0] CNT_D = 7'd64;
  localparam logic [6:0] CNT_W = 7'd32;
`endif

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;

  state_e            state_q;
  logic [XLEN-1:0]   rem_q, quo_q, dvs_q, result_q;
  logic [6:0]        cnt_q;
  logic              w_q, rem_sel_q, neg_quo_q, neg_rem_q;

  // func3[2] is always set for this unit's opcodes.
  logic unused_func3;
  assign unused_func3 = func3[2];

  // ---------------- operand preparation (IDLE capture) ----------------
  logic            is_signed;
  logic [XLEN-1:0] op_a, op_b, mag_a, mag_b;
  logic            sign_a, sign_b, div_zero, overflow;
  logic [XLEN-1:0] special_pick, special_res;

  always_comb begin
    is_signed = ~func3[0];
    if (w_en) begin
      op_a = is_signed ? {{32{rsA[31]}}, rsA[31:0]} : {32'b0, rsA[31:0]};
      op_b = is_signed ? {{32{rsB[31]}}, rsB[31:0]} : {32'b0, rsB[31:0]};
    end else begin
      op_a = rsA;
      op_b = rsB;
    end
    sign_a = is_signed & op_a[XLEN-1];
    sign_b = is_signed & op_b[XLEN-1];
    mag_a  = sign_a ? -op_a : op_a;
    mag_b  = sign_b ? -op_b : op_b;

    div_zero = w_en ? (rsB[31:0] == 32'b0) : (rsB == '0);
    overflow = is_signed & (w_en
             ? (rsA[31:0] == 32'h8000_0000 && rsB[31:0] == 32'hFFFF_FFFF)
             : (rsA == {1'b1, {(XLEN-1){1'b0}}} && rsB == '1));

    // Divide-by-zero: q = all ones, r = dividend. Overflow: q = dividend, r = 0.
    if (func3[1])
      special_pick = div_zero ? op_a : '0;
    else
      special_pick = div_zero ? '1 : op_a;
    special_res = w_en ? {{32{special_pick[31]}}, special_pick[31:0]} : special_pick;
  end

  // ---------------- iteration datapath ----------------
  // One restoring step: shift {rem, quo} left, trial-subtract the divisor.
  // The shifted remainder is < 2*divisor, so after a successful subtract
  // (or when it is kept) the new remainder fits in XLEN bits.
  function automatic logic [2*XLEN-1:0] div_step(input logic [XLEN-1:0] rem,
                                                 input logic [XLEN-1:0] quo,
                                                 input logic [XLEN-1:0] dvs);
    logic [XLEN:0]   sh;
    logic [XLEN-1:0] rem_n, quo_n;
    sh    = {rem, quo[XLEN-1]};
    quo_n = {quo[XLEN-2:0], 1'b0};
    if (sh >= {1'b0, dvs}) begin
      rem_n    = sh[XLEN-1:0] - dvs;
      quo_n[0] = 1'b1;
    end else begin
      rem_n = sh[XLEN-1:0];
    end
    return {rem_n, quo_n};
  endfunction

  logic [XLEN-1:0] step_rem_d, step_quo_d;
  logic [XLEN-1:0] q_raw, q_fix, r_fix, res_pick, final_res;

  always_comb begin
`ifdef YSYX_22041412_DIV_RADIX4_EN
    logic [XLEN-1:0] mid_rem, mid_quo;
    {mid_rem, mid_quo}       = div_step(rem_q, quo_q, dvs_q);
    {step_rem_d, step_quo_d} = div_step(mid_rem, mid_quo, dvs_q);
`else
    {step_rem_d, step_quo_d} = div_step(rem_q, quo_q, dvs_q);
`endif
    // W dividends enter at the top of quo, so after 32 shifts the quotient
    // sits in the low word.
    q_raw     = w_q ? {32'b0, step_quo_d[31:0]} : step_quo_d;
    q_fix     = neg_quo_q ? -q_raw : q_raw;
    r_fix     = neg_rem_q ? -step_rem_d : step_rem_d;
    res_pick  = rem_sel_q ? r_fix : q_fix;
    final_res = w_q ? {{32{res_pick[31]}}, res_pick[31:0]} : res_pick;
  end

  // ---------------- control ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      result_q  <= '0;
      cnt_q     <= '0;
      w_q       <= 1'b0;
      rem_sel_q <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (en && !flush) begin
            w_q       <= w_en;
            rem_sel_q <= func3[1];
            neg_quo_q <= sign_a ^ sign_b;
            neg_rem_q <= sign_a;
            if (div_zero || overflow) begin
              result_q <= special_res;
              state_q  <= S_DONE;
            end else begin
              rem_q   <= '0;
              quo_q   <= w_en ? {mag_a[31:0], 32'b0} : mag_a;
              dvs_q   <= mag_b;
              cnt_q   <= w_en ? CNT_W : CNT_D;
              state_q <= S_BUSY;
            end
          end
        end
        S_BUSY: begin
          if (flush) begin
            state_q <= S_IDLE;
          end else begin
            rem_q <= step_rem_d;
            quo_q <= step_quo_d;
            cnt_q <= cnt_q - 7'd1;
            if (cnt_q == 7'd1) begin
              result_q <= final_res;
              state_q  <= S_DONE;
            end
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ready_o = (state_q == S_DONE);
  assign busy_o  = (state_q == S_BUSY);
  assign result  = result_q;

endmodule

// File: tb/tb_ysyx_22041412_div.sv
// Self-checking bench for ysyx_22041412_div: directed cases, randomized
// operations against an arithmetic reference model, back-to-back requests,
// flush and asynchronous reset.
module tb_ysyx_22041412_div;

  logic        clk = 1'b0;
  logic        rst_n, en, w_en, flush;
  logic [63:0] rsA, rsB;
  logic [2:0]  func3;
  logic        ready_o, busy_o;
  logic [63:0] result;

  int checks   = 0;
  int failures = 0;

`ifdef YSYX_22041412_DIV_RADIX4_EN
  localparam int LAT_D   = 33;
  localparam int LAT_W   = 17;
  localparam int RST_CYC = 20;
`else
  localparam int LAT_D   = 65;
  localparam int LAT_W   = 33;
  localparam int RST_CYC = 40;
`endif

  always #5 clk = ~clk;

  ysyx_22041412_div dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (en),
    .w_en   (w_en),
    .flush  (flush),
    .rsA    (rsA),
    .rsB    (rsB),
    .func3  (func3),
    .ready_o(ready_o),
    .busy_o (busy_o),
    .result (result)
  );

  // ---------------- reference model (RISC-V M semantics) ----------------
  function automatic logic [63:0] ref_result(input logic [63:0] a, input logic [63:0] b,
                                             input logic [2:0] f3, input logic w);
    logic [31:0] a32, b32, q32, r32, p32;
    logic [63:0] q, r;
    a32 = a[31:0];
    b32 = b[31:0];
    if (w) begin
      if (b32 == 32'd0) begin
        q32 = '1; r32 = a32;
      end else if (!f3[0] && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) begin
        q32 = a32; r32 = 32'd0;
      end else if (f3[0]) begin
        q32 = a32 / b32; r32 = a32 % b32;
      end else begin
        q32 = 32'($signed(a32) / $signed(b32));
        r32 = 32'($signed(a32) % $signed(b32));
      end
      p32 = f3[1] ? r32 : q32;
      return {{32{p32[31]}}, p32};
    end
    if (b == 64'd0) begin
      q = '1; r = a;
    end else if (!f3[0] && a == 64'h8000_0000_0000_0000 && b == '1) begin
      q = a; r = 64'd0;
    end else if (f3[0]) begin
      q = a / b; r = a % b;
    end else begin
      q = 64'($signed(a) / $signed(b));
      r = 64'($signed(a) % $signed(b));
    end
    return f3[1] ? r : q;
  endfunction

  function automatic int exp_lat(input logic [63:0] a, input logic [63:0] b,
                                 input logic [2:0] f3, input logic w);
    if (w) begin
      if (b[31:0] == 32'd0) return 1;
      if (!f3[0] && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF) return 1;
      return LAT_W;
    end
    if (b == 64'd0) return 1;
    if (!f3[0] && a == 64'h8000_0000_0000_0000 && b == '1) return 1;
    return LAT_D;
  endfunction

  // One operation: request at cycle 0, operands scrambled from cycle 1,
  // en optionally dropped at drop_cyc (0 = keep until ready_o).
  task automatic run_op(input string name, input logic [63:0] a, input logic [63:0] b,
                        input logic [2:0] f3, input logic w, input logic [63:0] exp_res,
                        input int drop_cyc);
    int cyc, lat;
    bit seen;
    lat = exp_lat(a, b, f3, w);
    rsA = a; rsB = b; func3 = f3; w_en = w; en = 1'b1; flush = 1'b0;
    cyc = 0; seen = 0;
    while (!seen && cyc < 200) begin
      @(posedge clk); #1; cyc++;
      if (cyc == 1) begin
        rsA   = {$urandom(), $urandom()};
        rsB   = {$urandom(), $urandom()};
        func3 = 3'($urandom_range(4, 7));
        w_en  = 1'($urandom_range(0, 1));
        if (lat > 1) begin
          checks++;
          if (busy_o !== 1'b1) begin
            failures++;
            $display("FAIL %s busy: got %0b want 1", name, busy_o);
          end
        end
      end
      if (drop_cyc != 0 && cyc == drop_cyc) en = 1'b0;
      if (ready_o) seen = 1;
    end
    en = 1'b0;
    checks++;
    if (!seen || cyc != lat) begin
      failures++;
      $display("FAIL %s latency: got %0d (seen=%0b) want %0d", name, cyc, seen, lat);
    end
    checks++;
    if (result !== exp_res) begin
      failures++;
      $display("FAIL %s result: got %h want %h", name, result, exp_res);
    end
    @(posedge clk); #1;
    checks++;
    if (ready_o !== 1'b0 || busy_o !== 1'b0) begin
      failures++;
      $display("FAIL %s after_done: got ready=%0b busy=%0b want 0 0", name, ready_o, busy_o);
    end
    $display("op %-10s a=%h b=%h f3=%b w=%0b -> %h lat=%0d", name, a, b, f3, w, result, cyc);
  endtask

  task automatic test_reset();
    rst_n = 1'b1; en = 1'b0; w_en = 1'b0; flush = 1'b0;
    rsA = '0; rsB = '0; func3 = 3'b100;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (ready_o !== 1'b0 || busy_o !== 1'b0 || result !== 64'd0) begin
      failures++;
      $display("FAIL reset_hold: got ready=%0b busy=%0b result=%h want 0 0 0", ready_o, busy_o, result);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (ready_o !== 1'b0 || busy_o !== 1'b0 || result !== 64'd0) begin
      failures++;
      $display("FAIL reset_release: got ready=%0b busy=%0b result=%h want 0 0 0", ready_o, busy_o, result);
    end
    $display("reset ready=%0b busy=%0b result=%h", ready_o, busy_o, result);
  endtask

  task automatic test_directed();
    run_op("div",      64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 3'b100, 1'b0, 64'hFFFF_FFFF_FFFF_FFFD, 0);
    run_op("rem",      64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 3'b110, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 0);
    run_op("divuw",    64'hDEAD_BEEF_8000_0000, 64'd2, 3'b101, 1'b1, 64'h0000_0000_4000_0000, 0);
    run_op("remw",     64'h1234_5678_8000_0001, 64'd2, 3'b110, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 0);
    run_op("divu_z",   64'd123, 64'd0, 3'b101, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 0);
    run_op("remu_z",   64'd123, 64'd0, 3'b111, 1'b0, 64'd123, 0);
    run_op("div_ovf",  64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 3'b100, 1'b0,
           64'h8000_0000_0000_0000, 0);
    run_op("rem_ovf",  64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 3'b110, 1'b0, 64'd0, 0);
    run_op("divw_ovf", 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 3'b100, 1'b1,
           64'hFFFF_FFFF_8000_0000, 0);
    run_op("remuw_z",  64'h0000_0000_8000_0000, 64'hFFFF_FFFF_0000_0000, 3'b111, 1'b1,
           64'hFFFF_FFFF_8000_0000, 0);
    run_op("divuw_1",  64'h0000_0000_FFFF_FFFF, 64'd1, 3'b101, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 0);
    run_op("div_endrp", 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 3'b100, 1'b0, 64'hFFFF_FFFF_FFFF_FFF2, 3);
  endtask

  task automatic test_random();
    logic [63:0] a, b;
    logic [2:0]  f3;
    logic        w;
    for (int i = 0; i < 24; i++) begin
      a = {$urandom(), $urandom()};
      case ($urandom_range(0, 5))
        0:       b = 64'd0;
        1:       b = 64'($urandom_range(1, 15));
        2:       b = '1;
        3:       b = {$urandom(), $urandom()};
        4:       b = a >> $urandom_range(1, 40);
        default: b = {32'd0, $urandom()} >> $urandom_range(0, 20);
      endcase
      if ($urandom_range(0, 7) == 0) a = 64'h8000_0000_8000_0000;
      f3 = 3'($urandom_range(4, 7));
      w  = 1'($urandom_range(0, 1));
      run_op("random", a, b, f3, w, ref_result(a, b, f3, w), 0);
    end
  endtask

  task automatic test_back_to_back();
    int cyc, npulse;
    int pc[2];
    logic [63:0] pr[2];
    rsA = 64'd100; rsB = 64'd7; func3 = 3'b101; w_en = 1'b0; flush = 1'b0; en = 1'b1;
    cyc = 0; npulse = 0; pc[0] = 0; pc[1] = 0; pr[0] = '0; pr[1] = '0;
    while (cyc < 2 * LAT_D + 10) begin
      @(posedge clk); #1; cyc++;
      if (ready_o) begin
        if (npulse < 2) begin
          pc[npulse] = cyc;
          pr[npulse] = result;
        end
        npulse++;
        if (npulse == 1) func3 = 3'b111;
        else en = 1'b0;
      end
    end
    en = 1'b0;
    checks++;
    if (npulse != 2) begin
      failures++;
      $display("FAIL b2b pulses: got %0d want 2", npulse);
    end
    checks++;
    if (pc[0] != LAT_D || pc[1] != 2 * LAT_D + 1) begin
      failures++;
      $display("FAIL b2b cycles: got %0d,%0d want %0d,%0d", pc[0], pc[1], LAT_D, 2 * LAT_D + 1);
    end
    checks++;
    if (pr[0] !== 64'd14 || pr[1] !== 64'd2) begin
      failures++;
      $display("FAIL b2b results: got %0d,%0d want 14,2", pr[0], pr[1]);
    end
    $display("b2b pulses=%0d at %0d,%0d results %0d,%0d", npulse, pc[0], pc[1], pr[0], pr[1]);
  endtask

  task automatic test_flush();
    int npulse, nbusy;
    logic [63:0] prev;
    run_op("pre_flush", 64'd100, 64'd7, 3'b101, 1'b0, 64'd14, 0);
    prev = result;
    // flush during BUSY
    rsA = 64'd1000; rsB = 64'd3; func3 = 3'b101; w_en = 1'b0; en = 1'b1; flush = 1'b0;
    repeat (20) begin @(posedge clk); #1; end
    flush = 1'b1; en = 1'b0;
    @(posedge clk); #1;
    flush = 1'b0;
    checks++;
    if (busy_o !== 1'b0 || ready_o !== 1'b0) begin
      failures++;
      $display("FAIL flush_idle: got busy=%0b ready=%0b want 0 0", busy_o, ready_o);
    end
    npulse = 0;
    repeat (LAT_D + 10) begin
      @(posedge clk); #1;
      if (ready_o) npulse++;
    end
    checks++;
    if (npulse != 0 || result !== prev) begin
      failures++;
      $display("FAIL flush_busy: got pulses=%0d result=%h want 0 %h", npulse, result, prev);
    end
    // flush together with en in IDLE: flush wins
    en = 1'b1; flush = 1'b1;
    nbusy = 0; npulse = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (busy_o) nbusy++;
      if (ready_o) npulse++;
    end
    en = 1'b0; flush = 1'b0;
    checks++;
    if (nbusy != 0 || npulse != 0) begin
      failures++;
      $display("FAIL flush_en_idle: got busy_cycles=%0d pulses=%0d want 0 0", nbusy, npulse);
    end
    $display("flush result=%h", result);
    @(posedge clk); #1;
  endtask

  task automatic test_async_reset();
    rsA = 64'd5000; rsB = 64'd9; func3 = 3'b101; w_en = 1'b0; en = 1'b1; flush = 1'b0;
    repeat (RST_CYC) begin @(posedge clk); #1; end
    checks++;
    if (busy_o !== 1'b1) begin
      failures++;
      $display("FAIL arst_pre busy: got %0b want 1", busy_o);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (busy_o !== 1'b0 || ready_o !== 1'b0 || result !== 64'd0) begin
      failures++;
      $display("FAIL arst_async: got busy=%0b ready=%0b result=%h want 0 0 0", busy_o, ready_o, result);
    end
    en = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    checks++;
    if (busy_o !== 1'b0 || ready_o !== 1'b0) begin
      failures++;
      $display("FAIL arst_discard: got busy=%0b ready=%0b want 0 0", busy_o, ready_o);
    end
    $display("async reset busy=%0b ready=%0b result=%h", busy_o, ready_o, result);
    run_op("post_rst", 64'd5000, 64'd9, 3'b101, 1'b0, 64'd555, 0);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_flush();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ysyx_22041412_div.md
Name: ysyx_22041412_div

Overview:
- Iterative RV64M divide/remainder unit. It is the responder on the ALU's multi-cycle `en`/`ready_o` stall handshake, the same protocol the multiplier serves.
- Executes DIV/DIVU/REM/REMU and the W variants (DIVW/DIVUW/REMW/REMUW).
- Uses a radix-2 restoring algorithm, one quotient bit per cycle.
- The ALU holds `stall = en & !ready_o`, selects `result` when `ready_o` is high, and sign-extends nothing itself: W results come out already sign-extended.

Parameters:
- XLEN, 64, operand/result width. Only 64 is supported; W ops use the low 32 bits.

Ports:
- clk      input   1      clock, rising edge
- rst_n    input   1      asynchronous active-low reset
- en       input   1      request; held high by the ALU until `ready_o`
- w_en     input   1      1 = W variant (32-bit operation, sign-extended result)
- flush    input   1      abort any in-flight operation
- rsA      input   XLEN   dividend
- rsB      input   XLEN   divisor
- func3    input   3      100 DIV, 101 DIVU, 110 REM, 111 REMU
- ready_o  output  1      result valid this cycle (one-cycle pulse)
- busy_o   output  1      operation in progress (state BUSY)
- result   output  XLEN   quotient or remainder; holds its value until the next completion

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, ready_o=0, busy_o=0, result=0, counter=0, all datapath registers 0. Reset mid-operation discards the operation.
- States: IDLE, BUSY, DONE. ready_o=(state==DONE), busy_o=(state==BUSY), both decoded from registered state.
- IDLE:
  - If en & !flush: capture func3, w_en, operand magnitudes, quotient sign, remainder sign.
  - Go to DONE if a special case applies; otherwise go to BUSY with counter=64 (32 if w_en).
  - If flush: stay in IDLE.
- W operand prep:
  - signed: sign-extend rsA[31:0] and rsB[31:0].
  - unsigned: zero-extend rsA[31:0] and rsB[31:0].
  - Iterate over 32 bits only.
- Signed ops: divide magnitudes. Quotient is negated if sign(A)^sign(B); remainder takes sign(A).
- Special cases, resolved in one cycle (IDLE -> DONE):
  - divisor==0: quotient = all ones; remainder = dividend.
  - signed overflow (dividend = most negative, divisor = -1): quotient = dividend; remainder = 0.
  - For W, both checks apply to the 32-bit values and the result is sign-extended from bit 31.
- BUSY:
  - Each cycle: shift {rem, quo} left 1; trial-subtract divisor; if no borrow, keep the difference and set quo[0]=1. Counter decrements.
  - When counter reaches 1 (last iteration): go to DONE and write `result` (sign fix-up applied, W results sign-extended from bit 31).
- DONE: ready_o=1 for exactly one cycle, then IDLE unconditionally.
  - `en` still high in the following IDLE cycle is a new request (back-to-back divides).
  - No request is accepted while in DONE.
- Latency, request seen in IDLE at cycle 0:
  - 64-bit: ready_o in cycle 65.
  - W: ready_o in cycle 33.
  - special case: ready_o in cycle 1.
- Operand stability: rsA, rsB, func3 and w_en are sampled only on the IDLE capture edge. Later changes have no effect.
- flush:
  - In BUSY or DONE: next state IDLE; `result` is not updated and no ready_o pulse occurs (a DONE pulse already showing is that cycle's only pulse).
  - flush together with en in IDLE: flush wins.
- en dropping during BUSY without flush: the operation completes normally and ready_o still pulses.

Optional Feature:
- Macro: YSYX_22041412_DIV_RADIX4_EN.
- Defined: two quotient bits per cycle (two chained restoring stages). Counter loads 32 (16 for W). Latency becomes cycle 33 (64-bit) and cycle 17 (W). Special cases are still one cycle.
- Undefined: radix-2 as specified above.
- Results are bit-identical in both builds.

Test Plan:
- DIV, w_en=0, rsA=-7 (0xFFFF_FFFF_FFFF_FFF9), rsB=2, en held -> ready_o first high in cycle 65, result=0xFFFF_FFFF_FFFF_FFFD (-3); same operands with REM -> 0xFFFF_FFFF_FFFF_FFFF (-1).
- DIVUW, rsA=0xDEAD_BEEF_8000_0000, rsB=0x0000_0000_0000_0002 -> ready_o in cycle 33, result=0x0000_0000_4000_0000; REMW with rsA low word 0x8000_0001, rsB=2 -> result=0xFFFF_FFFF_FFFF_FFFF.
- Divide by zero: DIVU rsA=123, rsB=0 -> ready_o in cycle 1, result=0xFFFF_FFFF_FFFF_FFFF; REMU rsA=123, rsB=0 -> result=123. Overflow: DIV rsA=0x8000_0000_0000_0000, rsB=-1 -> result=0x8000_0000_0000_0000; REM -> 0.
- Back-to-back: en held through DIVU 100/7 then REMU 100/7 -> ready_o pulses in cycle 65 (result 14) and cycle 131 (result 2); ready_o low in all other cycles.
- flush asserted in BUSY at cycle 20 -> IDLE at cycle 21, no ready_o, result keeps its previous value; rst_n pulled low at cycle 40 of a new op -> outputs 0 immediately (asynchronous).
- With YSYX_22041412_DIV_RADIX4_EN defined: rerun the first two scenarios -> ready_o in cycles 33 and 17, identical results.
